// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bundle covering the memory port, the EX redirect and the decoder handoff.
interface if_fetch_if #(
   parameter int XLEN = 32
) ();
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_ready;
   logic            inst_valid;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   modport master (
      output mem_req, mem_addr, inst_valid, inst, inst_pc,
      input  mem_ack, mem_rdata, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  mem_req, mem_addr, inst_valid, inst, inst_pc,
      output mem_ack, mem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage; owns the PC, keeps one word fetch in flight and
// buffers returned words with their PC in a 2-entry FIFO for the decoder.
module if_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   if_fetch_if.master bus_io
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL} state_t;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h13);
   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [XLEN-1:0] inst_q [2];
   logic [XLEN-1:0] ipc_q [2];
   logic            rd_q, rd_d, wr_q, wr_d;
   logic [1:0]      cnt_q, cnt_d, occ;
   logic            push, pop, redir;
   always_comb begin
      redir  = bus_io.redirect_valid;
      pop    = (cnt_q != 2'd0) && bus_io.id_ready;
      push   = (state_q == S_REQ) && bus_io.mem_ack && !redir;
      occ    = cnt_q + {1'b0, push} - {1'b0, pop};
      cnt_d  = redir ? 2'd0 : occ;
      rd_d   = redir ? 1'b0 : rd_q ^ pop;
      wr_d   = redir ? 1'b0 : wr_q ^ push;
      pc_d   = redir ? {bus_io.redirect_pc[XLEN-1:2], 2'b00} : push ? pc_q + XLEN'(4) : pc_q;
      // remember the issued address so a killed fetch keeps its bus address stable
      addr_d = (state_q == S_REQ) ? pc_q : addr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = (!redir && cnt_d <= 2'd1) ? S_REQ : S_IDLE;
         S_REQ:   state_d = redir ? (bus_io.mem_ack ? S_IDLE : S_KILL)
                                  : (bus_io.mem_ack && occ > 2'd1) ? S_IDLE : S_REQ;
         S_KILL:  state_d = bus_io.mem_ack ? S_IDLE : S_KILL;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      bus_io.mem_req    = state_q != S_IDLE;
      bus_io.mem_addr   = (state_q == S_KILL) ? addr_q : pc_q;
      bus_io.inst_valid = cnt_q != 2'd0;
      bus_io.inst       = (cnt_q != 2'd0) ? inst_q[rd_q] : NOP;
      bus_io.inst_pc    = (cnt_q != 2'd0) ? ipc_q[rd_q] : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         addr_q <= RESET_PC;
         cnt_q  <= 2'd0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
      end
   always_ff @(posedge clk)
      if (push) begin
         inst_q[wr_q] <= bus_io.mem_rdata;
         ipc_q[wr_q]  <= pc_q;
      end
endmodule
